// File: rtl/gate_check_pkg.sv
// Shared types and helpers for the gate-block response checker.
// Holds the FSM state enum, response-bit positions, MISR polynomial and the
// truth-table model of the basic-gates block.
package gate_check_pkg;

  localparam int unsigned RESP_W = 9;
  localparam int unsigned SIG_W  = 16;

  // Bit positions inside the response word
  localparam int unsigned B_OR     = 0;
  localparam int unsigned B_NAND   = 1;
  localparam int unsigned B_XNOR   = 2;
  localparam int unsigned B_XOR    = 3;
  localparam int unsigned B_NOR    = 4;
  localparam int unsigned B_AND    = 5;
  localparam int unsigned B_BUF    = 6;
  localparam int unsigned B_INV    = 7;
  localparam int unsigned B_NOTIF1 = 8;

  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [RESP_W-1:0] val;
    logic [RESP_W-1:0] mask;
  } exp_resp_t;

  // Expected gate responses for vector v = {Enable,in2,in1}
  function automatic exp_resp_t exp_resp(input logic [2:0] v);
    exp_resp_t res;
    logic a;
    logic b;
    logic e;
    a = v[0];
    b = v[1];
    e = v[2];
    res.val            = '0;
    res.mask           = '1;
    res.val[B_OR]      = a | b;
    res.val[B_NAND]    = ~(a & b);
    res.val[B_XNOR]    = ~(a ^ b);
    res.val[B_XOR]     = a ^ b;
    res.val[B_NOR]     = ~(a | b);
    res.val[B_AND]     = a & b;
    res.val[B_BUF]     = a;
    res.val[B_INV]     = ~a;
    // notif1 floats when disabled, so it is neither compared nor signed
    res.val[B_NOTIF1]  = e & ~a;
    res.mask[B_NOTIF1] = e;
    return res;
  endfunction

endpackage

// File: rtl/gate_response_checker_misr16.sv
// 16-bit multiple-input signature register.
// Ports: clk/rst (async high), load_i reloads SEED, en_i folds data_i into
// the signature, sig_o is the registered signature.
module misr16
  import gate_check_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [RESP_W-1:0] data_i,
  output logic [SIG_W-1:0]  sig_o
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Load has priority over shift
  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (en_i) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? MISR_POLY : '0)
            ^ {(SIG_W-RESP_W)'(0), data_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= SEED;
    else     sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/gate_response_checker.sv
// Checked stimulus/response sequencer for the basic-gates block.
// Walks {Enable,in2,in1} through 0..7, waits SETTLE_CYCLES, samples the nine
// gate outputs, compares against the truth table and accumulates error count,
// first failing vector and a MISR signature.
// Ports: clk, rst (async high), start; stimulus in1/in2/Enable; gate responses
// out*; status busy/done/pass; results err_count, first_fail, signature.
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [15:0] MISR_SEED     = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        in1,
  output logic        in2,
  output logic        Enable,
  input  logic        outOr,
  input  logic        outNand,
  input  logic        outXnor,
  input  logic        outXor,
  input  logic        outNor,
  input  logic        outAnd,
  input  logic        outBuf,
  input  logic        outInv,
  input  logic        outNotIf1,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  err_count,
  output logic [2:0]  first_fail,
  output logic [15:0] signature
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [3:0]  ERR_MAX = 4'd8;

  state_e           state_q, state_d;
  logic [2:0]       v_q, v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [3:0]       err_q, err_d;
  logic [2:0]       ff_q, ff_d;

  logic              accept;
  logic              sample_en;
  logic [RESP_W-1:0] resp;
  logic [RESP_W-1:0] resp_masked;
  logic              mismatch;
  exp_resp_t         exp_w;

  assign resp = {outNotIf1, outInv, outBuf, outAnd, outNor,
                 outXor, outXnor, outNand, outOr};
  assign exp_w       = exp_resp(v_q);
  assign resp_masked = resp & exp_w.mask;
  assign mismatch    = |((resp ^ exp_w.val) & exp_w.mask);

  // Next-state and result update
  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    ff_d      = ff_q;
    accept    = 1'b0;
    sample_en = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          v_d     = '0;
          err_d   = '0;
          ff_d    = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          accept  = 1'b1;
        end
      end
      ST_DRIVE: begin
        state_d = ST_SETTLE;
        cnt_d   = CNT_W'(SETTLE_CYCLES);
      end
      ST_SETTLE: begin
        if (cnt_q <= CNT_W'(1)) state_d = ST_SAMPLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_SAMPLE: begin
        sample_en = 1'b1;
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 4'd1;
          if (err_q == 4'd0)    ff_d  = v_q;
        end
        if (v_q == 3'd7) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 4'd0);
        end else begin
          state_d = ST_DRIVE;
          v_d     = v_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  misr16 #(.SEED(MISR_SEED)) u_misr (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .en_i   (sample_en),
    .data_i (resp_masked),
    .sig_o  (signature)
  );

  assign in1        = v_q[0];
  assign in2        = v_q[1];
  assign Enable     = v_q[2];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench for gate_response_checker: a behavioural gate block with
// selectable faults feeds the DUT; expected run results are queued at start
// and checked by a monitor when done rises.
module tb_gate_response_checker;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned LAT    = 8 * (SETTLE + 2);

  logic clk, rst, start;
  logic in1, in2, Enable;
  logic outOr, outNand, outXnor, outXor, outNor, outAnd, outBuf, outInv, outNotIf1;
  logic busy, done, pass;
  logic [3:0]  err_count;
  logic [2:0]  first_fail;
  logic [15:0] signature;

  // 0 golden, 1 and stuck-0, 2 notif1 random when disabled, 3 inv stuck-1
  int   mode;
  logic rnd_bit;

  gate_response_checker #(.SETTLE_CYCLES(SETTLE), .MISR_SEED(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in1(in1), .in2(in2), .Enable(Enable),
    .outOr(outOr), .outNand(outNand), .outXnor(outXnor), .outXor(outXor),
    .outNor(outNor), .outAnd(outAnd), .outBuf(outBuf), .outInv(outInv),
    .outNotIf1(outNotIf1),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail), .signature(signature)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rnd_bit <= 1'($urandom_range(0, 1));
  end

  // Behavioural gate block with fault injection
  always_comb begin
    outOr     = in1 | in2;
    outNand   = ~(in1 & in2);
    outXnor   = ~(in1 ^ in2);
    outXor    = in1 ^ in2;
    outNor    = ~(in1 | in2);
    outAnd    = (mode == 1) ? 1'b0 : (in1 & in2);
    outBuf    = in1;
    outInv    = (mode == 3) ? 1'b1 : ~in1;
    outNotIf1 = Enable ? ~in1 : ((mode == 2) ? rnd_bit : 1'b0);
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Signature model built from the gate truth table, with the same faults
  function automatic logic [15:0] model_sig(input int m);
    logic [15:0] s;
    logic [8:0]  r;
    logic a, b, e;
    s = 16'hFFFF;
    for (int v = 0; v < 8; v++) begin
      a = v[0]; b = v[1]; e = v[2];
      r[0] = a | b;
      r[1] = ~(a & b);
      r[2] = ~(a ^ b);
      r[3] = a ^ b;
      r[4] = ~(a | b);
      r[5] = (m == 1) ? 1'b0 : (a & b);
      r[6] = a;
      r[7] = (m == 3) ? 1'b1 : ~a;
      r[8] = e ? ~a : 1'b0;
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {7'b0, r};
    end
    return s;
  endfunction

  typedef struct {
    int          start_cyc;
    logic        pass;
    logic [3:0]  err;
    logic [2:0]  ff;
    logic [15:0] sig;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_exp(input int m, input logic p, input logic [3:0] e, input logic [2:0] f);
    exp_t it;
    it.start_cyc = cyc;
    it.pass = p;
    it.err  = e;
    it.ff   = f;
    it.sig  = model_sig(m);
    exp_q.push_back(it);
  endtask

  // Monitor: on each rising done, pop and compare the oldest expectation
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t it;
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(exp_q.size()), 32'd1);
      end else begin
        it = exp_q.pop_front();
        check("latency",    32'(cyc - it.start_cyc), 32'(LAT));
        check("pass",       32'(pass),       32'(it.pass));
        check("err_count",  32'(err_count),  32'(it.err));
        check("first_fail", 32'(first_fail), 32'(it.ff));
        check("signature",  32'(signature),  32'(it.sig));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
    done_prev = done;
  end

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic accept_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int m, input logic p, input logic [3:0] e, input logic [2:0] f);
    mode = m;
    accept_start();
    push_exp(m, p, e, f);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in1"},    32'(in1),        32'd0);
    check({tag, "_in2"},    32'(in2),        32'd0);
    check({tag, "_en"},     32'(Enable),     32'd0);
    check({tag, "_busy"},   32'(busy),       32'd0);
    check({tag, "_done"},   32'(done),       32'd0);
    check({tag, "_pass"},   32'(pass),       32'd0);
    check({tag, "_err"},    32'(err_count),  32'd0);
    check({tag, "_ff"},     32'(first_fail), 32'd0);
    check({tag, "_sig"},    32'(signature),  32'hFFFF);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // Golden, and stuck-0, notif1 noise while disabled, inv stuck-1
    run(0, 1'b1, 4'd0, 3'd0);
    run(1, 1'b0, 4'd2, 3'd3);
    run(2, 1'b1, 4'd0, 3'd0);
    run(3, 1'b0, 4'd4, 3'd1);

    // Abort during vector-5 SETTLE
    mode = 0;
    accept_start();
    @(negedge clk);
    start = 1'b0;
    repeat (31) @(posedge clk);
    @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'd1);
    check("pre_abort_vec",  32'({Enable, in2, in1}), 32'd5);
    rst = 1'b1;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    rst = 1'b0;
    run(0, 1'b1, 4'd0, 3'd0);

    // start pulsed while busy is ignored
    mode = 0;
    accept_start();
    push_exp(0, 1'b1, 4'd0, 3'd0);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_mid", 32'(busy), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // start held through DONE: one-cycle done pulse and immediate restart
    mode = 0;
    accept_start();
    push_exp(0, 1'b1, 4'd0, 3'd0);
    wait_done();
    @(posedge clk);
    #1;
    push_exp(0, 1'b1, 4'd0, 3'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done();

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Self-checking response analyzer for the basic-gates cell library block. It drives `in1`, `in2` and `Enable` through all 8 input combinations and waits a programmable settle time after each one. It then samples the nine gate outputs, compares them against a built-in truth-table model, and accumulates an error count, the first failing vector and a 16-bit MISR signature. It sits in the bench/BIST wrapper around the gate block and replaces free-running toggle stimulus with a checked sequence.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles held after each new vector before sampling; legal range 1..255.
- `MISR_SEED`, default 16'hFFFF: signature value after reset and at each start.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begins a run when sampled high in IDLE or DONE; ignored while a run is busy.
- `in1`, `in2`, `Enable` output 1 each: stimulus to the gate block, registered.
- `outOr`, `outNand`, `outXnor`, `outXor`, `outNor`, `outAnd`, `outBuf`, `outInv`, `outNotIf1` input 1 each: gate block responses.
- `busy` output 1: high from the cycle after `start` is accepted until DONE is entered.
- `done` output 1: high in DONE and held until the next `start` or `rst`.
- `pass` output 1: valid when `done` is high; 1 if and only if `err_count` is 0.
- `err_count` output 4: number of vectors with at least one mismatch, range 0..8.
- `first_fail` output 3: index of the first mismatching vector; 0 if no vector failed.
- `signature` output 16: MISR over all sampled response words.

## Operation
- Vector index `v[2:0]` maps to `{Enable,in2,in1}` and runs 0 to 7, so `in1` toggles fastest.
- Response word `r[8:0]` is `{outNotIf1,outInv,outBuf,outAnd,outNor,outXor,outXnor,outNand,outOr}`.
- Expected values:
  - or = a|b, nand = ~(a&b), xnor = ~(a^b), xor = a^b, nor = ~(a|b), and = a&b, where a=`in1`, b=`in2`.
  - buf = a, inv = ~a.
  - notif1 = ~a when `Enable` is 1.
- When `Enable` is 0, bit 8 is masked out of the compare (high-Z) and forced to 0 before it enters the MISR.
- FSM states:
  - IDLE: on `start`, go to DRIVE. Set v=0, `err_count`=0, `first_fail`=0, `signature`=`MISR_SEED`, clear `done`.
  - DRIVE: present v on `in1`/`in2`/`Enable` for 1 cycle, then go to SETTLE.
  - SETTLE: hold for `SETTLE_CYCLES` cycles using an 8-bit down-counter, then go to SAMPLE.
  - SAMPLE: register r, compare it, update the MISR. If v=7 go to DONE; otherwise increment v and go to DRIVE.
  - DONE: hold all results. On `start`, behave as in IDLE.
- Error accounting: on a mismatch in SAMPLE, increment `err_count`. If `err_count` was 0 before this increment, also load `first_fail` with v. The count saturates at 8, which cannot be exceeded.
- MISR: polynomial 0x1021. Each SAMPLE computes next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {7'b0, r_masked}.

## Timing
- Reset values: `in1`/`in2`/`Enable`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail`=0, `signature`=`MISR_SEED`. State is IDLE.
- Latency: `done` rises 8×(`SETTLE_CYCLES`+2) cycles after the edge that accepts `start`.
- Sampling: the DUT response is sampled on the last cycle of SAMPLE. Stimulus is stable from DRIVE through SAMPLE.
- `start` held high through DONE restarts immediately, so `done` is high for exactly 1 cycle.
- `rst` asserted mid-run aborts the run. All outputs return to reset values asynchronously, and no partial results are retained.

## Structure
- Package `gate_check_pkg` holds:
  - the FSM state enum;
  - the response-bit index constants;
  - `MISR_POLY`=16'h1021;
  - an expected-response function `exp_resp(v)` returning 9 bits plus a 9-bit mask.
- Sub-module `misr16` contains the signature register with seed load and enable. The FSM, counters and compare logic live in the top module.

## Test plan
- Golden DUT (correct gates), `SETTLE_CYCLES`=4: `done` at cycle 48 after start, `pass`=1, `err_count`=0, `first_fail`=0. `signature` matches the bench model.
- `outAnd` stuck at 0: vectors 3 and 7 fail, giving `err_count`=2, `first_fail`=3, `pass`=0.
- `outNotIf1` driven to a random value while `Enable`=0 and correct otherwise: `pass`=1, and `signature` is identical to the golden run.
- `outInv` stuck at 1: vectors 1, 3, 5 and 7 fail, giving `err_count`=4, `first_fail`=1.
- `rst` pulsed during the vector-5 SETTLE state: all outputs return to reset values immediately. A following `start` gives a full golden result.
- `start` pulsed while `busy`: it is ignored and the total latency is unchanged. With `start` held high in DONE, `done` is a 1-cycle pulse and a new run begins.
